// File: rtl/xoodoo_perm_core.sv
// Xoodoo permutation engine for the Xoodyak datapath.
//
// This core computes NROUNDS rounds of Xoodoo on a 384-bit state. It does
// UNROLL rounds per clock and uses the last NROUNDS entries of the 12-entry
// round-constant table.
//
// Ports:
//   clk, resetn          clock; asynchronous active-low reset
//   in_valid / in_ready  input handshake for in_state
//                        (in_ready is combinational from out_ready and abort)
//   in_state             state to permute
//   out_valid / out_ready
//                        result handshake; out_state holds stable while stalled
//   out_state            the working register (don't-care until out_valid)
//   busy                 high while rounds are being computed
//   abort                synchronous cancel; returns to idle and outranks both
//                        handshakes
`timescale 1ns/1ps

module xoodoo_perm_core #(
    parameter int unsigned NROUNDS = 12,
    parameter int unsigned UNROLL  = 1
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [383:0] in_state,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [383:0] out_state,
    output logic         busy,
    input  logic         abort
);

    // Reject illegal configurations at elaboration.
    if (UNROLL == 0 || NROUNDS < 1 || NROUNDS > 12 || (NROUNDS % UNROLL) != 0) begin : g_bad_cfg
        $error("xoodoo_perm_core: illegal NROUNDS/UNROLL combination");
    end

    localparam logic [3:0] RcStart = 4'(12 - NROUNDS);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e       fsm_q, fsm_d;
    logic [383:0] st_q, st_d;
    logic [3:0]   rc_q, rc_d;
    logic [4:0]   rc_end;
    logic [383:0] round_chain;

    function automatic logic [31:0] rotl(input logic [31:0] v, input int unsigned n);
        return (v << n) | (v >> (32 - n));
    endfunction

    function automatic logic [31:0] rc_const(input logic [3:0] idx);
        case (idx)
            4'd0:    return 32'h058;
            4'd1:    return 32'h038;
            4'd2:    return 32'h3C0;
            4'd3:    return 32'h0D0;
            4'd4:    return 32'h120;
            4'd5:    return 32'h014;
            4'd6:    return 32'h060;
            4'd7:    return 32'h02C;
            4'd8:    return 32'h380;
            4'd9:    return 32'h0F0;
            4'd10:   return 32'h1A0;
            4'd11:   return 32'h012;
            default: return 32'h000;
        endcase
    endfunction

    // One full round: theta, rho-west, iota, chi, rho-east.
    function automatic logic [383:0] xoodoo_round(input logic [383:0] s,
                                                  input logic [31:0] c);
        logic [31:0] a [3][4];
        logic [31:0] b [3][4];
        logic [31:0] p [4];
        logic [31:0] e [4];
        logic [383:0] r;
        for (int y = 0; y < 3; y++) begin
            for (int x = 0; x < 4; x++) begin
                a[y][x] = s[32*(4*y+x) +: 32];
            end
        end
        for (int x = 0; x < 4; x++) begin
            p[x] = a[0][x] ^ a[1][x] ^ a[2][x];
        end
        for (int x = 0; x < 4; x++) begin
            e[x] = rotl(p[(x+3)%4], 5) ^ rotl(p[(x+3)%4], 14);
        end
        // theta and rho-west fused: b holds the post-rho-west planes.
        for (int x = 0; x < 4; x++) begin
            b[0][x] = a[0][x] ^ e[x];
            b[1][x] = a[1][(x+3)%4] ^ e[(x+3)%4];
            b[2][x] = rotl(a[2][x] ^ e[x], 11);
        end
        b[0][0] = b[0][0] ^ c;
        for (int y = 0; y < 3; y++) begin
            for (int x = 0; x < 4; x++) begin
                a[y][x] = b[y][x] ^ (~b[(y+1)%3][x] & b[(y+2)%3][x]);
            end
        end
        for (int x = 0; x < 4; x++) begin
            r[32*x       +: 32] = a[0][x];
            r[32*(4+x)   +: 32] = rotl(a[1][x], 1);
            r[32*(8+x)   +: 32] = rotl(a[2][(x+2)%4], 8);
        end
        return r;
    endfunction

    always_comb begin
        round_chain = st_q;
        for (int i = 0; i < int'(UNROLL); i++) begin
            round_chain = xoodoo_round(round_chain, rc_const(rc_q + 4'(i)));
        end
    end

    assign rc_end    = {1'b0, rc_q} + 5'(UNROLL);
    assign in_ready  = !abort && ((fsm_q == StIdle) || (fsm_q == StDone && out_ready));
    assign out_valid = (fsm_q == StDone);
    assign busy      = (fsm_q == StRun);
    assign out_state = st_q;

    always_comb begin
        fsm_d = fsm_q;
        st_d  = st_q;
        rc_d  = rc_q;
        case (fsm_q)
            StIdle: begin
                if (in_valid && in_ready) begin
                    st_d  = in_state;
                    rc_d  = RcStart;
                    fsm_d = StRun;
                end
            end
            StRun: begin
                if (abort) begin
                    fsm_d = StIdle;
                end else begin
                    st_d = round_chain;
                    rc_d = rc_q + 4'(UNROLL);
                    if (rc_end == 5'd12) begin
                        fsm_d = StDone;
                    end
                end
            end
            StDone: begin
                if (abort) begin
                    fsm_d = StIdle;
                end else if (out_ready) begin
                    // Back-to-back: a new state loads on the same edge as the
                    // result handshake.
                    if (in_valid) begin
                        st_d  = in_state;
                        rc_d  = RcStart;
                        fsm_d = StRun;
                    end else begin
                        fsm_d = StIdle;
                    end
                end
            end
            default: fsm_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            fsm_q <= StIdle;
            st_q  <= '0;
            rc_q  <= '0;
        end else begin
            fsm_q <= fsm_d;
            st_q  <= st_d;
            rc_q  <= rc_d;
        end
    end

endmodule

// File: tb/tb_xoodoo_perm_core.sv
// Self-checking bench for xoodoo_perm_core. Seven instances share the inputs:
// the default core, NROUNDS=1, and the UNROLL=2/3/4/6/12 variants.
`timescale 1ns/1ps

module tb_xoodoo_perm_core;

    localparam int NI = 7;

    logic         clk = 1'b0;
    logic         resetn = 1'b0;
    logic         in_valid = 1'b0;
    logic [383:0] in_state = '0;
    logic         out_ready = 1'b1;
    logic         abort = 1'b0;

    logic         ir [NI];
    logic         ov [NI];
    logic         bz [NI];
    logic [383:0] os [NI];

    int checks = 0;
    int failures = 0;

    // Expected latency and round count per instance.
    int lat_exp [NI] = '{12, 1, 6, 4, 3, 2, 1};
    int nr_of   [NI] = '{12, 1, 12, 12, 12, 12, 12};

    int           lat [NI];
    int           bcnt [NI];
    logic [383:0] res [NI];

    logic [31:0] rc_tab [12] = '{32'h058, 32'h038, 32'h3C0, 32'h0D0, 32'h120, 32'h014,
                                 32'h060, 32'h02C, 32'h380, 32'h0F0, 32'h1A0, 32'h012};

    always #5 clk = ~clk;

    xoodoo_perm_core u_d0 (.clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(ir[0]),
        .in_state(in_state), .out_valid(ov[0]), .out_ready(out_ready), .out_state(os[0]),
        .busy(bz[0]), .abort(abort));
    xoodoo_perm_core #(.NROUNDS(1), .UNROLL(1)) u_d1 (.clk(clk), .resetn(resetn),
        .in_valid(in_valid), .in_ready(ir[1]), .in_state(in_state), .out_valid(ov[1]),
        .out_ready(out_ready), .out_state(os[1]), .busy(bz[1]), .abort(abort));
    xoodoo_perm_core #(.NROUNDS(12), .UNROLL(2)) u_d2 (.clk(clk), .resetn(resetn),
        .in_valid(in_valid), .in_ready(ir[2]), .in_state(in_state), .out_valid(ov[2]),
        .out_ready(out_ready), .out_state(os[2]), .busy(bz[2]), .abort(abort));
    xoodoo_perm_core #(.NROUNDS(12), .UNROLL(3)) u_d3 (.clk(clk), .resetn(resetn),
        .in_valid(in_valid), .in_ready(ir[3]), .in_state(in_state), .out_valid(ov[3]),
        .out_ready(out_ready), .out_state(os[3]), .busy(bz[3]), .abort(abort));
    xoodoo_perm_core #(.NROUNDS(12), .UNROLL(4)) u_d4 (.clk(clk), .resetn(resetn),
        .in_valid(in_valid), .in_ready(ir[4]), .in_state(in_state), .out_valid(ov[4]),
        .out_ready(out_ready), .out_state(os[4]), .busy(bz[4]), .abort(abort));
    xoodoo_perm_core #(.NROUNDS(12), .UNROLL(6)) u_d5 (.clk(clk), .resetn(resetn),
        .in_valid(in_valid), .in_ready(ir[5]), .in_state(in_state), .out_valid(ov[5]),
        .out_ready(out_ready), .out_state(os[5]), .busy(bz[5]), .abort(abort));
    xoodoo_perm_core #(.NROUNDS(12), .UNROLL(12)) u_d6 (.clk(clk), .resetn(resetn),
        .in_valid(in_valid), .in_ready(ir[6]), .in_state(in_state), .out_valid(ov[6]),
        .out_ready(out_ready), .out_state(os[6]), .busy(bz[6]), .abort(abort));

    function automatic logic [31:0] rl(input logic [31:0] v, input int n);
        return (v << n) | (v >> (32 - n));
    endfunction

    // Reference Xoodoo on a flat 12-lane array, lane index 4*y+x.
    function automatic logic [383:0] ref_perm(input logic [383:0] s, input int nr);
        logic [31:0] l [12];
        logic [31:0] t [12];
        logic [31:0] p [4];
        logic [31:0] e [4];
        logic [383:0] r;
        for (int k = 0; k < 12; k++) l[k] = s[32*k +: 32];
        for (int rd = 12 - nr; rd < 12; rd++) begin
            for (int x = 0; x < 4; x++) p[x] = l[x] ^ l[4+x] ^ l[8+x];
            for (int x = 0; x < 4; x++) e[x] = rl(p[(x+3)%4], 5) ^ rl(p[(x+3)%4], 14);
            for (int k = 0; k < 12; k++) l[k] = l[k] ^ e[k%4];
            t = l;
            for (int x = 0; x < 4; x++) begin
                l[4+x] = t[4+((x+3)%4)];
                l[8+x] = rl(t[8+x], 11);
            end
            l[0] = l[0] ^ rc_tab[rd];
            t = l;
            for (int y = 0; y < 3; y++)
                for (int x = 0; x < 4; x++)
                    l[4*y+x] = t[4*y+x] ^ (~t[4*((y+1)%3)+x] & t[4*((y+2)%3)+x]);
            t = l;
            for (int x = 0; x < 4; x++) begin
                l[4+x] = rl(t[4+x], 1);
                l[8+x] = rl(t[8+((x+2)%4)], 8);
            end
        end
        for (int k = 0; k < 12; k++) r[32*k +: 32] = l[k];
        return r;
    endfunction

    function automatic logic [383:0] rand_state();
        logic [383:0] s;
        for (int k = 0; k < 12; k++) s[32*k +: 32] = $urandom;
        return s;
    endfunction

    // Drain every instance back to idle.
    task automatic settle();
        in_valid = 1'b0;
        abort = 1'b0;
        out_ready = 1'b1;
        repeat (14) @(posedge clk);
        #1;
    endtask

    // Start one operation on all instances and record latency, busy cycles
    // and result for each.
    task automatic run_op(input logic [383:0] s);
        settle();
        in_state = s;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int i = 0; i < NI; i++) begin
            lat[i] = -1;
            bcnt[i] = 0;
            res[i] = '0;
        end
        for (int cyc = 0; cyc <= 20; cyc++) begin
            if (cyc > 0) begin
                @(posedge clk); #1;
            end
            for (int i = 0; i < NI; i++) begin
                if (lat[i] < 0) begin
                    if (ov[i]) begin
                        lat[i] = cyc;
                        res[i] = os[i];
                    end else if (bz[i]) begin
                        bcnt[i]++;
                    end
                end
            end
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        #1;
        for (int i = 0; i < NI; i++) begin
            checks++;
            if (ov[i] !== 1'b0 || bz[i] !== 1'b0 || os[i] !== '0) begin
                failures++;
                $display("FAIL reset_state inst=%0d: got ov=%b busy=%b state=%h, expected 0/0/0",
                         i, ov[i], bz[i], os[i]);
            end
        end
        @(posedge clk); #2;
        resetn = 1'b1;
        #1;
        checks++;
        if (ir[0] !== 1'b1) begin
            failures++;
            $display("FAIL reset_in_ready: got %b expected 1", ir[0]);
        end
    endtask

    task automatic test_one_round();
        logic [383:0] exp_s;
        exp_s = '0;
        exp_s[31:0] = 32'h0000_0012;
        exp_s[159:128] = 32'h0000_0024;
        run_op('0);
        checks++;
        if (lat[1] !== 1) begin
            failures++;
            $display("FAIL one_round_latency: got %0d expected 1", lat[1]);
        end
        checks++;
        if (res[1] !== exp_s) begin
            failures++;
            $display("FAIL one_round_result: got %h expected %h", res[1], exp_s);
        end
    endtask

    task automatic test_default();
        logic [383:0] exp_s;
        exp_s = ref_perm('0, 12);
        run_op('0);
        checks++;
        if (lat[0] !== 12) begin
            failures++;
            $display("FAIL default_latency: got %0d expected 12", lat[0]);
        end
        checks++;
        if (bcnt[0] !== 12) begin
            failures++;
            $display("FAIL default_busy_cycles: got %0d expected 12", bcnt[0]);
        end
        checks++;
        if (res[0] !== exp_s) begin
            failures++;
            $display("FAIL default_zero_result: got %h expected %h", res[0], exp_s);
        end
    endtask

    task automatic test_unroll();
        logic [383:0] s;
        logic [383:0] exp_s;
        for (int n = 0; n < 50; n++) begin
            s = rand_state();
            exp_s = ref_perm(s, 12);
            run_op(s);
            for (int i = 0; i < NI; i++) begin
                if (i == 1) continue;
                checks++;
                if (lat[i] !== lat_exp[i] || res[i] !== exp_s) begin
                    failures++;
                    $display("FAIL unroll inst=%0d vec=%0d: got lat=%0d state=%h, expected lat=%0d state=%h",
                             i, n, lat[i], res[i], lat_exp[i], exp_s);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [383:0] s1;
        logic [383:0] s2;
        logic [383:0] e1;
        logic [383:0] e2;
        int n;
        int bad;
        s1 = rand_state();
        s2 = rand_state();
        e1 = ref_perm(s1, 12);
        e2 = ref_perm(s2, 12);
        settle();
        out_ready = 1'b0;
        in_state = s1;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 0;
        while (!ov[0] && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (ov[0] !== 1'b1) begin
            failures++;
            $display("FAIL stall_out_valid: got %b expected 1", ov[0]);
        end
        bad = 0;
        for (int c = 0; c < 20; c++) begin
            if (os[0] !== e1 || ir[0] !== 1'b0 || ov[0] !== 1'b1) bad++;
            @(posedge clk); #1;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL stall_stable: got %0d bad cycles, last state=%h in_ready=%b, expected 0 bad, state=%h in_ready=0",
                     bad, os[0], ir[0], e1);
        end
        in_state = s2;
        in_valid = 1'b1;
        out_ready = 1'b1;
        #1;
        checks++;
        if (ir[0] !== 1'b1) begin
            failures++;
            $display("FAIL handshake_in_ready: got %b expected 1", ir[0]);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++;
        if (bz[0] !== 1'b1 || ov[0] !== 1'b0) begin
            failures++;
            $display("FAIL back_to_back_accept: got busy=%b ov=%b expected busy=1 ov=0", bz[0], ov[0]);
        end
        n = 0;
        while (!ov[0] && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (n !== 12 || os[0] !== e2) begin
            failures++;
            $display("FAIL back_to_back_result: got lat=%0d state=%h expected lat=12 state=%h",
                     n, os[0], e2);
        end
    endtask

    task automatic test_abort();
        int seen;
        int n;
        logic [383:0] exp_s;
        exp_s = ref_perm('0, 12);
        settle();
        in_state = '0;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        abort = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (bz[0] !== 1'b0 || ov[0] !== 1'b0) begin
            failures++;
            $display("FAIL abort_run: got busy=%b ov=%b expected 0/0", bz[0], ov[0]);
        end
        abort = 1'b0;
        #1;
        checks++;
        if (ir[0] !== 1'b1) begin
            failures++;
            $display("FAIL abort_in_ready: got %b expected 1", ir[0]);
        end
        seen = 0;
        for (int c = 0; c < 14; c++) begin
            @(posedge clk); #1;
            if (ov[0]) seen++;
        end
        checks++;
        if (seen != 0) begin
            failures++;
            $display("FAIL abort_no_output: got %0d valid cycles expected 0", seen);
        end
        abort = 1'b1;
        #1;
        checks++;
        if (ir[0] !== 1'b0) begin
            failures++;
            $display("FAIL abort_idle_in_ready: got %b expected 0", ir[0]);
        end
        abort = 1'b0;
        // Abort in DONE outranks a simultaneous output and input handshake.
        out_ready = 1'b0;
        in_state = rand_state();
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 0;
        while (!ov[0] && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        in_valid = 1'b1;
        out_ready = 1'b1;
        abort = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (bz[0] !== 1'b0 || ov[0] !== 1'b0) begin
            failures++;
            $display("FAIL abort_done: got busy=%b ov=%b expected 0/0", bz[0], ov[0]);
        end
        abort = 1'b0;
        in_valid = 1'b0;
        run_op('0);
        checks++;
        if (lat[0] !== 12 || res[0] !== exp_s) begin
            failures++;
            $display("FAIL abort_recover: got lat=%0d state=%h expected lat=12 state=%h",
                     lat[0], res[0], exp_s);
        end
    endtask

    task automatic test_async_reset();
        logic [383:0] s;
        logic [383:0] exp_s;
        s = rand_state();
        exp_s = ref_perm(s, 12);
        settle();
        in_state = s;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #3;
        resetn = 1'b0;
        #1;
        checks++;
        if (ov[0] !== 1'b0 || bz[0] !== 1'b0 || os[0] !== '0) begin
            failures++;
            $display("FAIL reset_mid_run: got ov=%b busy=%b state=%h expected 0/0/0",
                     ov[0], bz[0], os[0]);
        end
        #2;
        resetn = 1'b1;
        settle();
        out_ready = 1'b0;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (14) @(posedge clk);
        #3;
        resetn = 1'b0;
        #1;
        checks++;
        if (ov[0] !== 1'b0 || bz[0] !== 1'b0 || os[0] !== '0) begin
            failures++;
            $display("FAIL reset_mid_done: got ov=%b busy=%b state=%h expected 0/0/0",
                     ov[0], bz[0], os[0]);
        end
        #2;
        resetn = 1'b1;
        run_op(s);
        checks++;
        if (lat[0] !== 12 || res[0] !== exp_s) begin
            failures++;
            $display("FAIL reset_recover: got lat=%0d state=%h expected lat=12 state=%h",
                     lat[0], res[0], exp_s);
        end
    endtask

    initial begin
        test_reset();
        test_one_round();
        test_default();
        test_unroll();
        test_back_to_back();
        test_abort();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
